// File: rtl/aes_ark_stage.sv
`default_nettype none
// ============================================================================
//  Module   : aes_ark_stage
//  Purpose  : Handshaked AddRoundKey stage with on-the-fly AES-128 key
//             expansion and a 2-entry output FIFO. Each accepted transfer
//             produces state^key, the next round key (Rcon taken from the
//             round index), the incremented round, a last-round flag and
//             the sideband tag.
//  Options  : AES_ARK_PERF_EN adds saturating perf_blocks / perf_stall
//             counters as extra output ports.
//  Revision : 1.0  initial release
// ============================================================================
module aes_ark_stage #(
    parameter int TAG_W     = 4,
    parameter int ROUND_W   = 4,
    parameter int MAX_ROUND = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_state,
    input  logic [127:0]       in_key,
    input  logic [ROUND_W-1:0] in_round,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_state,
    output logic [127:0]       out_key,
    output logic [ROUND_W-1:0] out_round,
    output logic               out_last,
    output logic [TAG_W-1:0]   out_tag,
    output logic               err_round
`ifdef AES_ARK_PERF_EN
    ,
    output logic [31:0]        perf_blocks,
    output logic [31:0]        perf_stall
`endif
);

    // Reset release is expected to be synchronised to clock upstream; the
    // flops here only need the asynchronous assertion.

    localparam logic [31:0]        C_MAX_ROUND_32 = MAX_ROUND;
    localparam logic [ROUND_W-1:0] C_MAX_ROUND    = ROUND_W'(MAX_ROUND);

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct packed {
        logic [127:0]       state;
        logic [127:0]       key;
        logic [ROUND_W-1:0] round;
        logic               last;
        logic [TAG_W-1:0]   tag;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

    // Byte at index a sits at bit offset (255-a)*8, i.e. {~a, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        return C_SBOX[{~a, 3'b000} +: 8];
    endfunction

    // ------------------------------------------------------------------
    // Datapath: AddRoundKey and one step of key expansion
    // ------------------------------------------------------------------
    logic [ROUND_W-1:0] w_round_next;
    logic [31:0]        w_round_next_ext;
    logic [7:0]         w_rcon;
    logic [31:0]        w_w0, w_w1, w_w2, w_w3;
    logic [31:0]        w_rot;
    logic [31:0]        w_sub;
    logic [31:0]        w_t;
    logic [31:0]        w_n0, w_n1, w_n2, w_n3;
    logic               w_bad_round;
    entry_t             w_entry;

    assign w_round_next     = in_round + 1'b1;
    assign w_round_next_ext = 32'(w_round_next);
    assign w_bad_round      = 32'(in_round) >= C_MAX_ROUND_32;

    assign {w_w0, w_w1, w_w2, w_w3} = in_key;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    // One S-box table per byte lane of SubWord
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        assign w_sub[gi*8 +: 8] = sbox(w_rot[gi*8 +: 8]);
    end

    // Rcon lookup on the round being produced; anything outside 1..10 is 00
    always_comb begin
        w_rcon = 8'h00;
        case (w_round_next_ext)
            32'd1:   w_rcon = 8'h01;
            32'd2:   w_rcon = 8'h02;
            32'd3:   w_rcon = 8'h04;
            32'd4:   w_rcon = 8'h08;
            32'd5:   w_rcon = 8'h10;
            32'd6:   w_rcon = 8'h20;
            32'd7:   w_rcon = 8'h40;
            32'd8:   w_rcon = 8'h80;
            32'd9:   w_rcon = 8'h1b;
            32'd10:  w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_t  = w_sub ^ {w_rcon, 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign w_entry.state = in_state ^ in_key;
    assign w_entry.key   = {w_n0, w_n1, w_n2, w_n3};
    assign w_entry.round = w_round_next;
    assign w_entry.last  = (w_round_next == C_MAX_ROUND);
    assign w_entry.tag   = in_tag;

    // ------------------------------------------------------------------
    // 2-entry FIFO: head_q is always the presented entry, tail_q the next
    // ------------------------------------------------------------------
    fifo_state_t state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    logic        in_ready_q, in_ready_d;
    logic        err_q, err_d;
    logic        w_push, w_pop;

    assign w_push = in_valid && in_ready_q;
    assign w_pop  = (state_q != ST_EMPTY) && out_ready;

    // FIFO next-state, storage update, registered ready and sticky error
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        err_d   = err_q | (w_push && w_bad_round);
        case (state_q)
            ST_EMPTY: begin
                if (w_push) begin
                    head_d  = w_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    head_d = w_entry;
                end else if (w_push) begin
                    tail_d  = w_entry;
                    state_d = ST_FULL;
                end else if (w_pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can happen
                if (w_pop) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        in_ready_d = (state_d != ST_FULL);
    end

    // State and storage registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_state = head_q.state;
    assign out_key   = head_q.key;
    assign out_round = head_q.round;
    assign out_last  = head_q.last;
    assign out_tag   = head_q.tag;
    assign err_round = err_q;

`ifdef AES_ARK_PERF_EN
    logic [31:0] perf_blocks_q, perf_blocks_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating counters for output transfers and stalled cycles
    always_comb begin
        perf_blocks_d = perf_blocks_q;
        perf_stall_d  = perf_stall_q;
        if (w_pop && (perf_blocks_q != 32'hffff_ffff)) begin
            perf_blocks_d = perf_blocks_q + 32'd1;
        end
        if ((state_q != ST_EMPTY) && !out_ready && (perf_stall_q != 32'hffff_ffff)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_blocks_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_blocks_q <= perf_blocks_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_blocks = perf_blocks_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_ark_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_ark_stage
//  Purpose  : Directed self-checking bench for aes_ark_stage (FIPS-197
//             vectors, backpressure, streaming, error flag and reset).
//  Options  : AES_ARK_PERF_EN checks the perf counters as well.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_ark_stage;

    logic         clock;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic [3:0]   in_round;
    logic [3:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         out_last;
    logic [3:0]   out_tag;
    logic         err_round;
`ifdef AES_ARK_PERF_EN
    logic [31:0]  perf_blocks;
    logic [31:0]  perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    aes_ark_stage #(.TAG_W(4), .ROUND_W(4), .MAX_ROUND(10)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_round  (in_round),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_key   (out_key),
        .out_round (out_round),
        .out_last  (out_last),
        .out_tag   (out_tag),
        .err_round (err_round)
`ifdef AES_ARK_PERF_EN
        ,
        .perf_blocks (perf_blocks),
        .perf_stall  (perf_stall)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;
        in_key    = '0;
        in_round  = '0;
        in_tag    = '0;
        reset_n   = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (err_round !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_round); end
        checks++;
        if ({out_state, out_key, out_round, out_last, out_tag} !== '0) begin
            errors++; $display("FAIL reset_outputs: state %h key %h want all zero", out_state, out_key);
        end
    endtask

    task automatic test_fips_round0();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = 128'h3243f6a8885a308d313198a2e0370734;
        in_key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        in_round  = 4'd0;
        in_tag    = 4'd5;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL r0_valid: got %b want 1", out_valid); end
        checks++;
        if (out_state !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
            errors++; $display("FAIL r0_state: got %h want 193de3bea0f4e22b9ac68d2ae9f84808", out_state);
        end
        checks++;
        if (out_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++; $display("FAIL r0_key: got %h want a0fafe1788542cb123a339392a6c7605", out_key);
        end
        checks++;
        if (out_round !== 4'd1 || out_last !== 1'b0 || out_tag !== 4'd5) begin
            errors++; $display("FAIL r0_side: round %0d last %b tag %0d want 1 0 5", out_round, out_last, out_tag);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL r0_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_rcon();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = '0;
        in_key    = 128'ha0fafe1788542cb123a339392a6c7605;
        in_round  = 4'd1;
        in_tag    = 4'd6;
        tick();
        checks++;
        if (out_key !== 128'hf2c295f27a96b9435935807a7359f67f || out_round !== 4'd2 || out_last !== 1'b0) begin
            errors++; $display("FAIL rcon02: key %h round %0d last %b want f2c295f27a96b9435935807a7359f67f 2 0",
                               out_key, out_round, out_last);
        end
        in_key   = 128'hac7766f319fadc2128d12941575c006e;
        in_round = 4'd9;
        in_tag   = 4'd7;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++; $display("FAIL rcon36_key: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", out_key);
        end
        checks++;
        if (out_round !== 4'd10 || out_last !== 1'b1 || out_state !== 128'hac7766f319fadc2128d12941575c006e) begin
            errors++; $display("FAIL rcon36_side: round %0d last %b state %h want 10 1 key", out_round, out_last, out_state);
        end
        checks++;
        if (err_round !== 1'b0) begin errors++; $display("FAIL round9_no_err: got %b want 0", err_round); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = '0;
        in_key    = '0;
        in_tag    = 4'd1;
        in_round  = 4'd1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
        in_tag   = 4'd2;
        in_round = 4'd2;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
        in_tag   = 4'd3;
        in_round = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_round !== 4'd2 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_stall: valid %b tag %0d round %0d ready %b want 1 1 2 0",
                                   out_valid, out_tag, out_round, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_tag !== 4'd2 || out_round !== 4'd3 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_second: tag %0d round %0d ready %b want 2 3 1", out_tag, out_round, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd3 || out_round !== 4'd4) begin
            errors++; $display("FAIL bp_third: valid %b tag %0d round %0d want 1 3 4", out_valid, out_tag, out_round);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int bubbles;
        int not_ready;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = 128'h0123456789abcdef0123456789abcdef;
        in_key    = '0;
        bubbles   = 0;
        not_ready = 0;
        for (int i = 0; i < 20; i++) begin
            in_tag   = 4'(i);
            in_round = 4'(i % 9);
            tick();
            if (out_valid !== 1'b1 || out_tag !== 4'(i) || out_round !== 4'((i % 9) + 1)) bubbles++;
            if (in_ready !== 1'b1) not_ready++;
        end
        in_valid = 1'b0;
        checks++;
        if (bubbles !== 0) begin errors++; $display("FAIL stream_order: %0d bad cycles want 0", bubbles); end
        checks++;
        if (not_ready !== 0) begin errors++; $display("FAIL stream_ready: %0d low cycles want 0", not_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", out_valid); end
`ifdef AES_ARK_PERF_EN
        checks++;
        if (perf_blocks !== 32'd20) begin errors++; $display("FAIL perf_blocks: got %0d want 20", perf_blocks); end
        checks++;
        if (perf_stall !== 32'd0) begin errors++; $display("FAIL perf_stall: got %0d want 0", perf_stall); end
`endif
    endtask

    task automatic test_err_and_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = 128'h11;
        in_key    = 128'h22;
        in_round  = 4'd10;
        in_tag    = 4'd9;
        tick();
        in_valid = 1'b0;
        checks++;
        if (err_round !== 1'b1 || out_round !== 4'd11 || out_last !== 1'b0 || out_state !== 128'h33) begin
            errors++; $display("FAIL err_set: err %b round %0d last %b state %h want 1 11 0 33",
                               err_round, out_round, out_last, out_state);
        end
        tick();
        tick();
        checks++;
        if (err_round !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_round); end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_round  = 4'd2;
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL full_before_reset: ready %b valid %b want 0 1", in_ready, out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || err_round !== 1'b0 || out_state !== '0) begin
            errors++; $display("FAIL async_reset: valid %b err %b state %h want 0 0 0", out_valid, err_round, out_state);
        end
        tick();
        #2 reset_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL after_release: ready %b valid %b want 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fips_round0();
        test_rcon();
        test_backpressure();
        test_back_to_back();
        test_err_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_ark_stage.md
Name: aes_ark_stage

Overview:
- Handshaked, buffered AddRoundKey plus on-the-fly AES-128 key-expansion stage.
- Each accepted transfer yields:
  - state XOR round key;
  - the next round key, with Rcon derived internally from the round index instead of a port;
  - incremented round index, last-round flag and sideband tag.
- Sits between SubBytes/ShiftRows/MixColumns stages in the round pipeline; chained N times or iterated by a round controller.

Parameters:
- TAG_W, 4, width of sideband tag carried alongside data (replaces the old empty flag).
- ROUND_W, 4, width of round index.
- MAX_ROUND, 10, final round number; drives out_last and err_round.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transfer valid
- in_ready  out  1  stage can accept; registered
- in_state  in  128  state, byte 0 at [127:120]
- in_key  in  128  current round key, word w0 at [127:96]
- in_round  in  ROUND_W  round index of in_key (0 = cipher key)
- in_tag  in  TAG_W  sideband, passed unchanged
- out_valid  out  1  output holds valid entry
- out_ready  in  1  downstream accepts
- out_state  out  128  in_state ^ in_key
- out_key  out  128  expanded key for round in_round+1
- out_round  out  ROUND_W  in_round+1, truncated to ROUND_W
- out_last  out  1  out_round == MAX_ROUND
- out_tag  out  TAG_W  in_tag of same entry
- err_round  out  1  sticky: transfer accepted with in_round >= MAX_ROUND

Behaviour:
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Once out_valid is asserted, it and all output data hold stable until the output transfer.
- Computation is combinational on input; the result is written into a 2-entry FIFO (entries of state, key, round, last, tag).
- Key expansion:
  - t = SubWord(RotWord(w3)) ^ {rcon,00,00,00}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - SubWord uses four internal 256-entry S-box tables.
- Rcon(r), for r = in_round+1:
  - Rcon(1) = 01.
  - Rcon(r+1) = xtime(Rcon(r)), where xtime shifts left 1 and XORs 1B if bit7 was set.
  - Sequence: 01,02,04,08,10,20,40,80,1B,36.
  - Implemented as a 16-entry lookup on the round index; indices above 10 yield 00.
- FIFO states: EMPTY (count 0), ONE (1), FULL (2).
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE, with the new entry behind the popped one.
  - FULL: pop -> ONE; no push possible.
  - in_ready is registered = next count < 2. It deasserts the cycle after the FIFO fills, so there is no combinational path from out_ready.
- Latency and throughput:
  - Latency 1 cycle: data accepted at edge N is presented on out_* after edge N.
  - Full throughput of 1 transfer/cycle when out_ready is held high.
- out_* always show the head entry; out_valid = count != 0.
- err_round:
  - Set on accept when in_round >= MAX_ROUND; that entry is still processed, with Rcon 00.
  - Cleared only by reset.
- Reset (async assert, sync release):
  - count = 0; out_valid = 0; in_ready = 1 after release.
  - All FIFO storage and outputs read 0; err_round = 0.
  - Reset mid-operation discards all buffered entries.

Optional Feature:
- Macro AES_ARK_PERF_EN.
- When defined, adds two output ports:
  - perf_blocks (32 bits): increments on every output transfer.
  - perf_stall (32 bits): increments every cycle with out_valid && !out_ready.
  - Both saturate at FFFFFFFF and reset to 0.
- When undefined, both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- FIPS-197 round 0, in_round=0, in_key=2b7e151628aed2a6abf7158809cf4f3c, in_state=3243f6a8885a308d313198a2e0370734 -> one cycle later:
  - out_state=193de3bea0f4e22b9ac68d2ae9f84808;
  - out_key=a0fafe1788542cb123a339392a6c7605;
  - out_round=1, out_last=0.
- in_key=a0fafe1788542cb123a339392a6c7605, in_round=1 -> out_key=f2c295f27a96b9435935807a7359f67f (Rcon 02).
- in_key=ac7766f319fadc2128d12941575c006e, in_round=9 -> out_key=d014f9a8c9ee2589e13f0cc8b6630ca6 (Rcon 36), out_last=1.
- Backpressure: out_ready=0, three back-to-back inputs with tags 1,2,3 -> in_ready low after two accepts; tag 3 held until out_ready=1; outputs emerge in order 1,2,3 with out_valid/data stable while stalled.
- Streaming: in_valid and out_ready high for 20 cycles -> 20 outputs, no bubbles, in_ready constantly 1; with AES_ARK_PERF_EN, perf_blocks=20 and perf_stall=0.
- in_round=10 accepted -> err_round=1 and sticky. Then assert reset_n=0 while FIFO FULL -> out_valid=0, err_round=0 immediately (asynchronously); in_ready=1 after release.
